score_accum: RTL and testbench



---
 rtl/score_pkg.sv | 33 +++
 rtl/sat_add.sv | 51 +++++
 rtl/score_accum.sv | 157 +++++++++++++++
 tb/tb_score_accum.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the score accumulator.
//   game_state_t : game FSM encoding (IDLE, PLAY, OVER)
//   bcd_max      : packed-BCD all-nines value for a given bit width
//   prio_idx     : index of the lowest set bit of a vector (0 when empty)
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // All-nines BCD pattern covering width/4 digits (up to 16 digits).
  function automatic logic [63:0] bcd_max(input int width);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width / 4) r[i*4 +: 4] = 4'h9;
    end
    return r;
  endfunction

  // Lowest set bit among the first n bits of v; 0 when none is set.
  function automatic int prio_idx(input logic [63:0] v, input int n);
    int idx;
    idx = 0;
    for (int i = 63; i >= 0; i--) begin
      if (i < n && v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational saturating adder, packed-BCD or unsigned binary.
//   i_a, i_b : operands in the active radix (W bits)
//   o_sum    : i_a + i_b, clamped to the radix maximum on overflow
//   o_sat    : high when the result was clamped
module sat_add
  import score_pkg::*;
#(
  parameter int W        = 16,
  parameter bit BCD_MODE = 1'b1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_sat
);

  generate
    if (BCD_MODE) begin : g_bcd
      localparam int NDIG = W / 4;
      localparam logic [W-1:0] MAX_VAL = W'(bcd_max(W));

      logic [NDIG:0]  w_carry;
      logic [W-1:0]   w_sum;

      assign w_carry[0] = 1'b0;

      // One decimal digit per nibble: binary add, then +6 correction when
      // the digit exceeds 9, which also produces the decimal carry.
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        logic [4:0] w_raw;
        logic [4:0] w_adj;
        logic       w_gt9;
        assign w_raw = {1'b0, i_a[gi*4 +: 4]} + {1'b0, i_b[gi*4 +: 4]}
                     + {4'b0, w_carry[gi]};
        assign w_adj = w_raw + 5'd6;
        assign w_gt9 = (w_raw > 5'd9);
        assign w_sum[gi*4 +: 4] = w_gt9 ? w_adj[3:0] : w_raw[3:0];
        assign w_carry[gi+1]    = w_gt9;
      end

      assign o_sat = w_carry[NDIG];
      assign o_sum = w_carry[NDIG] ? MAX_VAL : w_sum;
    end else begin : g_bin
      logic [W:0] w_full;
      assign w_full = {1'b0, i_a} + {1'b0, i_b};
      assign o_sat  = w_full[W];
      assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
    end
  endgenerate

endmodule

// File: rtl/score_accum.sv
// Per-level score accumulator with event awards, finish bonus and high score.
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_game_start     : level-sensitive start/restart request
//   i_player_alive   : player status; low in PLAY ends the game
//   i_evt_alive      : per-channel target alive flags (falling edge = kill)
//   i_bg_position    : background scroll position used for gating/finish
//   o_score          : running score
//   o_hi_score       : best completed score since reset
//   o_game_over      : high in OVER
//   o_won            : OVER was reached via the finish line
//   o_busy           : awards still pending
module score_accum
  import score_pkg::*;
#(
  parameter int                       N_EVT      = 3,
  parameter int                       SCORE_W    = 16,
  parameter int                       POS_W      = 16,
  parameter bit                       BCD_MODE   = 1'b1,
  parameter logic [N_EVT*SCORE_W-1:0] EVT_PTS    = {16'h0030, 16'h0020, 16'h0010},
  parameter logic [N_EVT*POS_W-1:0]   EVT_GATE   = {16'd1298, 16'd648, 16'd0},
  parameter logic [POS_W-1:0]         FINISH_POS = 16'd1300,
  parameter logic [SCORE_W-1:0]       FINISH_PTS = 16'h0050
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_game_start,
  input  logic               i_player_alive,
  input  logic [N_EVT-1:0]   i_evt_alive,
  input  logic [POS_W-1:0]   i_bg_position,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_hi_score,
  output logic               o_game_over,
  output logic               o_won,
  output logic               o_busy
);

  // One pending slot per channel plus the finish bonus in the top slot.
  localparam int N_P   = N_EVT + 1;
  localparam int IDX_W = (N_P > 1) ? $clog2(N_P) : 1;
  localparam logic [SCORE_W-1:0] SCORE_SAT =
    BCD_MODE ? SCORE_W'(bcd_max(SCORE_W)) : {SCORE_W{1'b1}};

  game_state_t        r_state;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_hi_score;
  logic               r_game_over;
  logic               r_won;
  logic               r_busy;
  logic [N_EVT-1:0]   r_evt_q;
  logic [N_P-1:0]     r_pending;
  logic               r_fin_done;
  logic               r_hi_done;

  logic [N_EVT-1:0]   w_edge;
  logic [N_P-1:0]     w_set;
  logic [N_P-1:0]     w_serve;
  logic [N_P-1:0]     w_pending_next;
  logic [IDX_W-1:0]   w_sel;
  logic [SCORE_W-1:0] w_pts_tab [N_P];
  logic [SCORE_W-1:0] w_sum;
  logic               w_sat;
  logic               w_in_play;
  logic               w_finish;

  assign w_in_play = (r_state == PLAY);
  assign w_edge    = r_evt_q & ~i_evt_alive;
  assign w_finish  = w_in_play && (i_bg_position > FINISH_POS) && !r_fin_done;

  generate
    for (genvar gi = 0; gi < N_EVT; gi++) begin : g_chan
      assign w_pts_tab[gi] = EVT_PTS[gi*SCORE_W +: SCORE_W];
      assign w_set[gi]     = w_in_play && w_edge[gi]
                           && (i_bg_position > EVT_GATE[gi*POS_W +: POS_W]);
    end
  endgenerate

  assign w_pts_tab[N_EVT] = FINISH_PTS;
  assign w_set[N_EVT]     = w_finish;

  // Serve the lowest pending slot; a fresh capture on that same slot is
  // OR-ed back in after the clear so it is not lost.
  assign w_sel          = IDX_W'(prio_idx(64'(r_pending), N_P));
  assign w_serve        = (|r_pending) ? (N_P'(1) << w_sel) : '0;
  assign w_pending_next = (r_pending & ~w_serve) | w_set;

  sat_add #(
    .W       (SCORE_W),
    .BCD_MODE(BCD_MODE)
  ) u_sat_add (
    .i_a  (r_score),
    .i_b  (w_pts_tab[w_sel]),
    .o_sum(w_sum),
    .o_sat(w_sat)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_score     <= '0;
      r_hi_score  <= '0;
      r_game_over <= 1'b0;
      r_won       <= 1'b0;
      r_busy      <= 1'b0;
      r_evt_q     <= '0;
      r_pending   <= '0;
      r_fin_done  <= 1'b0;
      r_hi_done   <= 1'b0;
    end else begin
      r_evt_q <= i_evt_alive;
      if (i_game_start) begin
        // Restart from any state; edges in this cycle are dropped.
        r_state     <= PLAY;
        r_score     <= '0;
        r_game_over <= 1'b0;
        r_won       <= 1'b0;
        r_busy      <= 1'b0;
        r_pending   <= '0;
        r_fin_done  <= 1'b0;
        r_hi_done   <= 1'b0;
      end else begin
        r_pending <= w_pending_next;
        r_busy    <= |w_pending_next;
        if (|r_pending) r_score <= w_sat ? SCORE_SAT : w_sum;
        case (r_state)
          IDLE: ;
          PLAY: begin
            if (w_finish) begin
              r_fin_done  <= 1'b1;
              r_state     <= OVER;
              r_game_over <= 1'b1;
              r_won       <= 1'b1;
            end else if (!i_player_alive) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
              r_won       <= 1'b0;
            end
          end
          OVER: begin
            // Latch the high score once, after every award has landed.
            if (!(|r_pending) && !r_busy && !r_hi_done) begin
              if (r_score > r_hi_score) r_hi_score <= r_score;
              r_hi_done <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_score     = r_score;
  assign o_hi_score  = r_hi_score;
  assign o_game_over = r_game_over;
  assign o_won       = r_won;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_score_accum.sv
module tb_score_accum;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        game_start;
  logic        player_alive;
  logic [2:0]  evt_alive;
  logic [15:0] bg_position;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic        game_over;
  logic        won;
  logic        busy;

  logic [7:0]  a8, b8, s8;
  logic        sat8;
  logic [15:0] a16, b16, s16;
  logic        sat16;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_accum dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_game_start  (game_start),
    .i_player_alive(player_alive),
    .i_evt_alive   (evt_alive),
    .i_bg_position (bg_position),
    .o_score       (score),
    .o_hi_score    (hi_score),
    .o_game_over   (game_over),
    .o_won         (won),
    .o_busy        (busy)
  );

  sat_add #(.W(8), .BCD_MODE(1'b1)) u_bcd8 (
    .i_a(a8), .i_b(b8), .o_sum(s8), .o_sat(sat8)
  );

  sat_add #(.W(16), .BCD_MODE(1'b0)) u_bin16 (
    .i_a(a16), .i_b(b16), .o_sum(s16), .o_sat(sat16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0; game_start = 1'b0; player_alive = 1'b1;
    evt_alive = 3'b111; bg_position = 16'd0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    step(); step();
    check("rst_score", score, 16'h0000);
    check("rst_hi", hi_score, 16'h0000);
    check("rst_over", 16'(game_over), 16'h0);
    check("rst_won", 16'(won), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);

    // Basic award
    reset_n = 1'b1; game_start = 1'b1; step();
    game_start = 1'b0; bg_position = 16'd100; evt_alive = 3'b110; step();
    check("basic_busy1", 16'(busy), 16'h1);
    check("basic_score0", score, 16'h0000);
    step();
    check("basic_score", score, 16'h0010);
    check("basic_busy0", 16'(busy), 16'h0);

    // Simultaneous edges
    game_start = 1'b1; evt_alive = 3'b111; step();
    check("sim_clear", score, 16'h0000);
    game_start = 1'b0; bg_position = 16'd1299; evt_alive = 3'b000; step();
    check("sim_busy_a", 16'(busy), 16'h1);
    step();
    check("sim_s1", score, 16'h0010);
    check("sim_busy_b", 16'(busy), 16'h1);
    step();
    check("sim_s2", score, 16'h0030);
    check("sim_busy_c", 16'(busy), 16'h1);
    step();
    check("sim_s3", score, 16'h0060);
    check("sim_busy_d", 16'(busy), 16'h0);

    // BCD carry
    evt_alive = 3'b111; step();
    evt_alive = 3'b011; step(); step();
    check("bcd_090", score, 16'h0090);
    evt_alive = 3'b111; step();
    evt_alive = 3'b101; step(); step();
    check("bcd_110", score, 16'h0110);

    // Gating
    game_start = 1'b1; evt_alive = 3'b111; bg_position = 16'd600; step();
    game_start = 1'b0; evt_alive = 3'b101; step();
    check("gate_busy", 16'(busy), 16'h0);
    step();
    check("gate_score", score, 16'h0000);
    evt_alive = 3'b100; step();
    check("gate_ch0_busy", 16'(busy), 16'h1);
    step();
    check("gate_ch0_score", score, 16'h0010);

    // Death with pending awards
    game_start = 1'b1; evt_alive = 3'b111; step();
    game_start = 1'b0; bg_position = 16'd700; evt_alive = 3'b100; step();
    check("death_busy", 16'(busy), 16'h1);
    player_alive = 1'b0; step();
    check("death_over", 16'(game_over), 16'h1);
    check("death_won", 16'(won), 16'h0);
    check("death_drain1", score, 16'h0010);
    step();
    check("death_drain2", score, 16'h0030);
    check("death_busy0", 16'(busy), 16'h0);
    step();
    check("death_hi", hi_score, 16'h0030);
    player_alive = 1'b1; game_start = 1'b1; evt_alive = 3'b111; step();
    check("restart_score", score, 16'h0000);
    check("restart_hi", hi_score, 16'h0030);
    check("restart_over", 16'(game_over), 16'h0);
    game_start = 1'b0; evt_alive = 3'b110; step(); step();
    check("low_score", score, 16'h0010);
    player_alive = 1'b0; step(); step(); step();
    check("low_hi_kept", hi_score, 16'h0030);
    check("low_over", 16'(game_over), 16'h1);

    // Finish bonus
    player_alive = 1'b1; game_start = 1'b1; evt_alive = 3'b111;
    bg_position = 16'd1300; step();
    game_start = 1'b0; step();
    check("fin_1300_over", 16'(game_over), 16'h0);
    check("fin_1300_busy", 16'(busy), 16'h0);
    bg_position = 16'd1301; step();
    check("fin_over", 16'(game_over), 16'h1);
    check("fin_won", 16'(won), 16'h1);
    check("fin_busy", 16'(busy), 16'h1);
    step();
    check("fin_score", score, 16'h0050);
    evt_alive = 3'b110; step();
    check("over_no_cap", 16'(busy), 16'h0);
    step();
    check("fin_once", score, 16'h0050);
    check("fin_hi", hi_score, 16'h0050);

    // Edge in the game_start cycle is ignored
    game_start = 1'b1; evt_alive = 3'b111; bg_position = 16'd100; step();
    evt_alive = 3'b110; step();
    check("gs_edge_busy", 16'(busy), 16'h0);
    game_start = 1'b0; step();
    check("gs_edge_score", score, 16'h0000);
    check("gs_edge_busy2", 16'(busy), 16'h0);

    // Reset mid-PLAY, reset beats game_start
    evt_alive = 3'b111; step();
    evt_alive = 3'b110; step(); step();
    check("pre_rst_score", score, 16'h0010);
    reset_n = 1'b0; game_start = 1'b1; step();
    check("mid_rst_score", score, 16'h0000);
    check("mid_rst_hi", hi_score, 16'h0000);
    check("mid_rst_over", 16'(game_over), 16'h0);
    check("mid_rst_won", 16'(won), 16'h0);
    check("mid_rst_busy", 16'(busy), 16'h0);
    reset_n = 1'b1; game_start = 1'b0; evt_alive = 3'b111; step();
    evt_alive = 3'b110; step();
    check("idle_busy", 16'(busy), 16'h0);
    step();
    check("idle_score", score, 16'h0000);

    // Adder radix / saturation corners
    a8 = 8'h95; b8 = 8'h10; #1;
    check("bcd8_sat_sum", 16'(s8), 16'h0099);
    check("bcd8_sat_flag", 16'(sat8), 16'h1);
    a8 = 8'h45; b8 = 8'h38; #1;
    check("bcd8_sum", 16'(s8), 16'h0083);
    check("bcd8_flag", 16'(sat8), 16'h0);
    a16 = 16'hFFF8; b16 = 16'h0010; #1;
    check("bin16_sat_sum", s16, 16'hFFFF);
    check("bin16_sat_flag", 16'(sat16), 16'h1);
    a16 = 16'h1234; b16 = 16'h0010; #1;
    check("bin16_sum", s16, 16'h1244);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
